// File: rtl/la_pkg.sv
// Shared types and default sizes for the logic-analyser capture block.
package la_pkg;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 11;
    localparam int DEPTH      = 2**DEF_ADDR_W;

    typedef enum logic [2:0] {
        IDLE, PRE, WAIT_TRIG, POST, DONE, READOUT
    } cap_state_t;
endpackage

// File: rtl/la_trig_cmp.sv
// Masked equality compare: a sample matches when every masked bit equals the trigger value.
module la_trig_cmp
    import la_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [DATA_W-1:0] sample,
    input  logic [DATA_W-1:0] mask,
    input  logic [DATA_W-1:0] value,
    output logic              match
);
    assign match = ((sample ^ value) & mask) == '0;
endmodule

// File: rtl/capture_sequencer.sv
// Circular-buffer capture sequencer: pre-trigger fill, masked trigger, post fill,
// then ordered readout from an external 1-cycle-latency BRAM.
module capture_sequencer
    import la_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              arm,
    input  logic              abort,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] trig_mask,
    input  logic [DATA_W-1:0] trig_value,
    input  logic [ADDR_W-1:0] pretrig,
    input  logic              rd_start,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              bram_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_din,
    input  logic [DATA_W-1:0] bram_dout,
    output logic              busy,
    output logic              triggered,
    output logic              done,
    output logic [ADDR_W-1:0] trig_addr
);
    localparam int                BUF_DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] LAST      = ADDR_W'(BUF_DEPTH-1);

    cap_state_t        state, state_nxt;
    logic [ADDR_W-1:0] wr_ptr, rd_ptr, pre_q, cnt, rd_cnt, rd_base;
    logic [DATA_W-1:0] rd_hold;
    logic              rd_first, match, hit, rd_acc, pre_last, post_last;

    la_trig_cmp #(.DATA_W(DATA_W)) u_trig (
        .sample(sample_in), .mask(trig_mask), .value(trig_value), .match(match)
    );

    assign hit       = (state == WAIT_TRIG) && sample_valid && match;
    assign rd_acc    = rd_valid && rd_ready;
    assign pre_last  = sample_valid && (cnt == pre_q - ADDR_W'(1));
    assign post_last = sample_valid && (cnt == ADDR_W'(BUF_DEPTH-2) - pre_q);
    assign rd_base   = trig_addr - pre_q;
    // First valid cycle passes the BRAM output through; later cycles replay the held copy.
    assign rd_data   = rd_first ? bram_dout : rd_hold;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (arm)                           state_nxt = (pretrig == '0) ? WAIT_TRIG : PRE;
                    else if (state == DONE && rd_start) state_nxt = READOUT;
                end
                PRE:       if (pre_last)  state_nxt = WAIT_TRIG;
                WAIT_TRIG: if (hit)       state_nxt = (pre_q == LAST) ? DONE : POST;
                POST:      if (post_last) state_nxt = DONE;
                READOUT:   if (rd_acc && rd_cnt == LAST) state_nxt = DONE;
                default:   state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            PRE, WAIT_TRIG, POST: busy = 1'b1;
            DONE:                 done = 1'b1;
            READOUT: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            trig_addr <= '0;
            pre_q     <= '0;
            cnt       <= '0;
            rd_cnt    <= '0;
            rd_hold   <= '0;
            rd_first  <= 1'b0;
            rd_valid  <= 1'b0;
            triggered <= 1'b0;
            bram_en   <= 1'b0;
            bram_we   <= 1'b0;
            bram_addr <= '0;
            bram_din  <= '0;
        end else if (abort) begin
            bram_en   <= 1'b0;
            bram_we   <= 1'b0;
            rd_valid  <= 1'b0;
            rd_first  <= 1'b0;
            triggered <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    bram_en <= 1'b0;
                    bram_we <= 1'b0;
                    if (arm) begin
                        // An ADDR_W-wide pretrig can never exceed DEPTH-1, so no clamp is needed.
                        pre_q     <= pretrig;
                        wr_ptr    <= '0;
                        cnt       <= '0;
                        triggered <= 1'b0;
                    end else if (state == DONE && rd_start) begin
                        bram_en   <= 1'b1;
                        bram_addr <= rd_base;
                        rd_ptr    <= rd_base + ADDR_W'(1);
                        rd_cnt    <= '0;
                    end
                end
                PRE, WAIT_TRIG, POST: begin
                    bram_en <= sample_valid;
                    bram_we <= sample_valid;
                    if (sample_valid) begin
                        bram_addr <= wr_ptr;
                        bram_din  <= sample_in;
                        wr_ptr    <= wr_ptr + ADDR_W'(1);
                        cnt       <= cnt + ADDR_W'(1);
                    end
                    if (hit) begin
                        trig_addr <= wr_ptr;
                        triggered <= 1'b1;
                        cnt       <= '0;
                    end
                end
                READOUT: begin
                    bram_we <= 1'b0;
                    if (bram_en) begin
                        bram_en  <= 1'b0;
                        rd_valid <= 1'b1;
                        rd_first <= 1'b1;
                    end
                    if (rd_valid) begin
                        rd_first <= 1'b0;
                        if (rd_first) rd_hold <= bram_dout;
                    end
                    if (rd_acc) begin
                        rd_valid <= 1'b0;
                        rd_cnt   <= rd_cnt + ADDR_W'(1);
                        if (rd_cnt != LAST) begin
                            bram_en   <= 1'b1;
                            bram_addr <= rd_ptr;
                            rd_ptr    <= rd_ptr + ADDR_W'(1);
                        end
                    end
                end
                default: begin
                    bram_en <= 1'b0;
                    bram_we <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_capture_sequencer.sv
// Bench for capture_sequencer: scenario table with a sample-history reference model,
// plus hand sequences for abort and asynchronous reset.
module tb_capture_sequencer;
    import la_pkg::*;

    localparam int DW = 8;
    localparam int AW = 11;

    logic          CLK, RST_N, arm, abort, sample_valid, rd_start, rd_valid, rd_ready;
    logic [DW-1:0] sample_in, trig_mask, trig_value, rd_data, bram_din, bram_dout;
    logic [AW-1:0] pretrig, bram_addr, trig_addr;
    logic          bram_en, bram_we, busy, triggered, done;

    capture_sequencer #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .CLK(CLK), .RST_N(RST_N), .arm(arm), .abort(abort),
        .sample_in(sample_in), .sample_valid(sample_valid),
        .trig_mask(trig_mask), .trig_value(trig_value), .pretrig(pretrig),
        .rd_start(rd_start), .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
        .bram_din(bram_din), .bram_dout(bram_dout),
        .busy(busy), .triggered(triggered), .done(done), .trig_addr(trig_addr)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // External BRAM: registered read, 1-cycle latency, output held while disabled.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge CLK) begin
        if (bram_en) begin
            if (bram_we) mem[bram_addr] <= bram_din;
            else         bram_dout      <= mem[bram_addr];
        end
    end

    typedef struct {
        int        pre;
        logic [7:0] mask;
        logic [7:0] val;
        int        trig_at;    // valid-sample index where the trigger value is planted
        int        gap_pct;    // percentage of cycles without sample_valid
        bit        rnd;        // random data instead of a ramp
        int        ready_mode; // 0: always ready, 1: 1-of-3, 2: 50%
        int        nread;
        int        exp_taddr;
    } vec_t;

    vec_t       vecs [5];
    int         tests, fails;
    logic [7:0] samp [$];      // every valid sample since arm, in order
    int         t_idx, P;
    logic [7:0] M, V;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic bit mt(input logic [7:0] s, input logic [7:0] m, input logic [7:0] v);
        return ((s ^ v) & m) == 8'h00;
    endfunction

    task automatic capture(input vec_t c);
        bit         v, exp_done;
        logic [7:0] s;
        int         k, n;
        samp.delete();
        t_idx = -1; P = c.pre; M = c.mask; V = c.val;
        @(negedge CLK);
        arm = 1'b1; pretrig = AW'(P); trig_mask = M; trig_value = V;
        @(negedge CLK);
        arm = 1'b0;
        chk("busy_after_arm", 32'(busy), 32'd1);
        chk("trig_clr_on_arm", 32'(triggered), 32'd0);
        chk("done_clr_on_arm", 32'(done), 32'd0);
        for (int cyc = 0; ; cyc++) begin
            if (cyc > 20000) begin
                chk("capture_timeout", 32'd0, 32'd1);
                break;
            end
            v = ($urandom_range(99) >= c.gap_pct);
            k = samp.size();
            s = c.rnd ? 8'($urandom) : 8'(k);
            if (k >= P) begin
                if (k == c.trig_at) s = V;
                else if (mt(s, M, V)) s = s ^ M;
            end
            sample_valid = v; sample_in = s;
            arm      = ($urandom_range(40) == 0);
            rd_start = ($urandom_range(40) == 0);
            if (v) begin
                samp.push_back(s);
                if (t_idx < 0 && k >= P && mt(s, M, V)) t_idx = k;
            end
            @(negedge CLK);
            n = samp.size();
            exp_done = (t_idx >= 0) && (n >= t_idx + DEPTH - P);
            chk("wr_en", 32'(bram_en), 32'(v));
            chk("wr_we", 32'(bram_we), 32'(v));
            if (v) begin
                chk("wr_addr", 32'(bram_addr), 32'((n - 1) % DEPTH));
                chk("wr_din", 32'(bram_din), 32'(s));
            end
            chk("triggered", 32'(triggered), 32'(t_idx >= 0));
            if (t_idx >= 0) chk("trig_addr", 32'(trig_addr), 32'(t_idx % DEPTH));
            chk("done", 32'(done), 32'(exp_done));
            chk("busy", 32'(busy), 32'(!exp_done));
            if (exp_done) break;
        end
        sample_valid = 1'b0; arm = 1'b0; rd_start = 1'b0;
        chk("trig_addr_table", 32'(trig_addr), 32'(c.exp_taddr));
    endtask

    task automatic readout(input int mode);
        int         k, cyc, base;
        bit         r, prev_v, prev_r;
        logic [7:0] prev_d;
        base = t_idx - P;
        k = 0; cyc = 0; prev_v = 1'b0; prev_r = 1'b0; prev_d = '0;
        @(negedge CLK);
        rd_start = 1'b1;
        @(negedge CLK);
        rd_start = 1'b0;
        while (k < DEPTH) begin
            if (cyc > 10 * DEPTH) begin
                chk("readout_timeout", 32'd0, 32'd1);
                break;
            end
            if (rd_valid) begin
                if (prev_v && !prev_r) chk("rd_hold", 32'(rd_data), 32'(prev_d));
                chk("rd_data", 32'(rd_data), 32'(samp[base + k]));
            end
            chk("rd_busy", 32'(busy), 32'd1);
            chk("rd_done", 32'(done), 32'd1);
            chk("rd_no_write", 32'(bram_we), 32'd0);
            r = (mode == 0) ? 1'b1 : (mode == 1) ? ($urandom_range(2) == 0) : 1'($urandom_range(1));
            rd_ready = r;
            arm      = ($urandom_range(40) == 0);
            rd_start = ($urandom_range(40) == 0);
            prev_v = rd_valid; prev_r = r; prev_d = rd_data;
            if (rd_valid && r) k++;
            @(negedge CLK);
            cyc++;
        end
        rd_ready = 1'b0; arm = 1'b0; rd_start = 1'b0;
        chk("rd_end_valid", 32'(rd_valid), 32'd0);
        chk("rd_end_done", 32'(done), 32'd1);
        chk("rd_end_busy", 32'(busy), 32'd0);
        if (mode == 0) chk("rd_rate", 32'(cyc <= 2 * DEPTH + 2), 32'd1);
    endtask

    initial begin
        tests = 0; fails = 0;
        RST_N = 1'b0; arm = 1'b0; abort = 1'b0; sample_valid = 1'b0; sample_in = '0;
        trig_mask = '0; trig_value = '0; pretrig = '0; rd_start = 1'b0; rd_ready = 1'b0;

        vecs[0] = '{4,    8'hFF, 8'hA5, 200,  0,  1'b0, 0, 1, 200};
        vecs[1] = '{0,    8'h00, 8'h5A, 0,    50, 1'b1, 1, 1, 0};
        vecs[2] = '{2047, 8'hFF, 8'h3C, 2100, 20, 1'b0, 2, 2, 52};
        vecs[3] = '{100,  8'hF0, 8'h70, 900,  30, 1'b1, 2, 1, 900};
        vecs[4] = '{1,    8'h0F, 8'h05, 1,    10, 1'b1, 0, 1, 1};

        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_triggered", 32'(triggered), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_bram_en", 32'(bram_en), 32'd0);
        chk("rst_bram_we", 32'(bram_we), 32'd0);
        chk("rst_bram_addr", 32'(bram_addr), 32'd0);
        chk("rst_bram_din", 32'(bram_din), 32'd0);
        chk("rst_trig_addr", 32'(trig_addr), 32'd0);
        #20 RST_N = 1'b1;

        @(negedge CLK);
        rd_start = 1'b1;
        @(negedge CLK);
        rd_start = 1'b0;
        chk("rd_start_in_idle_busy", 32'(busy), 32'd0);
        chk("rd_start_in_idle_en", 32'(bram_en), 32'd0);

        foreach (vecs[i]) begin
            capture(vecs[i]);
            for (int r = 0; r < vecs[i].nread; r++) readout(vecs[i].ready_mode);
        end

        // Asynchronous reset in the middle of a readout.
        @(negedge CLK);
        rd_start = 1'b1;
        @(negedge CLK);
        rd_start = 1'b0;
        @(negedge CLK);
        chk("pre_rst_rd_valid", 32'(rd_valid), 32'd1);
        #2 RST_N = 1'b0;
        #1;
        chk("midrd_rst_busy", 32'(busy), 32'd0);
        chk("midrd_rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("midrd_rst_bram_en", 32'(bram_en), 32'd0);
        chk("midrd_rst_done", 32'(done), 32'd0);
        chk("midrd_rst_trig_addr", 32'(trig_addr), 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;

        // Abort in POST, asserted together with arm, rd_start and a matching sample.
        @(negedge CLK);
        arm = 1'b1; pretrig = AW'(4); trig_mask = 8'h00; trig_value = 8'h00;
        @(negedge CLK);
        arm = 1'b0;
        sample_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sample_in = 8'(i);
            @(negedge CLK);
        end
        chk("post_triggered", 32'(triggered), 32'd1);
        chk("post_trig_addr", 32'(trig_addr), 32'd4);
        chk("post_busy", 32'(busy), 32'd1);
        abort = 1'b1; arm = 1'b1; rd_start = 1'b1;
        @(negedge CLK);
        abort = 1'b0; arm = 1'b0; rd_start = 1'b0; sample_valid = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_triggered", 32'(triggered), 32'd0);
        chk("abort_bram_en", 32'(bram_en), 32'd0);
        chk("abort_rd_valid", 32'(rd_valid), 32'd0);
        @(negedge CLK);
        chk("abort_stays_idle", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/capture_sequencer.md
CAPTURE_SEQUENCER -- requirements
Module: capture_sequencer

Interface
REQ-001 Parameter DATA_W, 8: sample width in bits.
REQ-002 Parameter ADDR_W, 11: buffer address width; DEPTH = 2**ADDR_W = 2048 samples.
REQ-003 CLK  in  1  sole clock; all state changes on rising edge.
REQ-004 RST_N  in  1  asynchronous, active-low reset.
REQ-005 arm  in  1  single-cycle pulse; starts a capture.
REQ-006 abort  in  1  level; forces return to IDLE.
REQ-007 sample_in  in  DATA_W  probe sample.
REQ-008 sample_valid  in  1  sample_in is valid this cycle.
REQ-009 trig_mask, trig_value  in  DATA_W each  trigger compare mask and value.
REQ-010 pretrig  in  ADDR_W  number of samples to keep before the trigger; latched on arm.
REQ-011 rd_start  in  1  single-cycle pulse; starts readout.
REQ-012 rd_data  out  DATA_W  readout sample; rd_valid  out  1; rd_ready  in  1.
REQ-013 bram_en, bram_we  out  1 each; bram_addr  out  ADDR_W; bram_din  out  DATA_W; bram_dout  in  DATA_W (registered, 1-cycle read latency).
REQ-014 busy, triggered, done  out  1 each; trig_addr  out  ADDR_W, buffer address of the trigger sample.

Function
REQ-015 States SHALL be IDLE, PRE, WAIT_TRIG, POST, DONE, READOUT.
REQ-016 IDLE or DONE with arm: latch pretrig (clamped to DEPTH-1), wr_ptr=0, clear triggered/done, go to PRE, or to WAIT_TRIG if pretrig==0.
REQ-017 In PRE, WAIT_TRIG and POST, each sample_valid cycle SHALL write sample_in at wr_ptr (bram_en=bram_we=1) and increment wr_ptr modulo DEPTH; there are no writes without sample_valid.
REQ-018 PRE SHALL go to WAIT_TRIG after exactly pretrig valid samples have been written; the trigger is not evaluated during PRE.
REQ-019 Trigger hit = sample_valid and ((sample_in XOR trig_value) AND trig_mask)==0; trig_mask==0 SHALL trigger on the first valid sample in WAIT_TRIG.
REQ-020 On a hit: the sample is written, trig_addr=wr_ptr, triggered=1, and the next state is POST.
REQ-021 POST SHALL write DEPTH-1-pretrig further valid samples, then enter DONE with done=1; total written from the trigger onward is DEPTH-pretrig.
REQ-022 The pre-trigger buffer wraps freely; wr_ptr wrap from DEPTH-1 to 0 SHALL NOT affect state.
REQ-023 DONE with rd_start: go to READOUT; rd_ptr = trig_addr-pretrig mod DEPTH; 2048 samples are read in ascending order with wrap.
REQ-024 READOUT: issue a read (bram_en=1, bram_we=0); one cycle later present bram_dout on rd_data with rd_valid=1; hold both stable until rd_valid and rd_ready; then issue the next read. Maximum rate is 1 sample per 2 cycles.
REQ-025 After the DEPTH-th accepted sample: rd_valid=0, return to DONE. Buffer contents and trig_addr are retained, so readout can be repeated.
REQ-026 arm SHALL be ignored in PRE/WAIT_TRIG/POST/READOUT; rd_start SHALL be ignored outside DONE.
REQ-027 abort has priority over arm, rd_start and trigger in the same cycle: IDLE next cycle, bram_en=0, rd_valid=0, triggered/done cleared.
REQ-028 busy=1 in PRE, WAIT_TRIG, POST, READOUT; done=1 only in DONE and READOUT.
REQ-029 bram_din SHALL equal sample_in registered with its write strobe so address, data and enable align on the same edge.

Reset
REQ-030 RST_N low SHALL asynchronously force IDLE; all outputs 0; wr_ptr, rd_ptr, trig_addr, latched pretrig 0.
REQ-031 Reset mid-capture or mid-readout SHALL abandon the operation; memory contents are undefined afterwards.

Structure
REQ-032 Package la_pkg SHALL hold the state enum cap_state_t, DATA_W/ADDR_W defaults and DEPTH.
REQ-033 Sub-module la_trig_cmp (combinational mask/value match) SHALL be used; the BRAM itself is external.

Verification
REQ-034 pretrig=4, mask=FF, value=A5, ramp 00..FF with A5 first at sample 200: trig_addr=200, triggered at that edge, done after 2043 further valid samples.
REQ-035 Continuing REQ-034, rd_start with rd_ready=1: first rd_data=C4 (sample 196), 5th=A5, 2048 beats, then rd_valid=0 and state DONE.
REQ-036 rd_ready toggled 1-of-3 during readout: rd_data stable while rd_valid&!rd_ready; no sample dropped or duplicated (ramp sequence intact).
REQ-037 pretrig=0, mask=00: trigger on first valid sample after arm, trig_addr=0; sample_valid gaps produce no writes.
REQ-038 abort asserted in POST and, separately, RST_N pulsed in READOUT: IDLE next cycle/immediately, busy=0, rd_valid=0, bram_en=0.
REQ-039 pretrig=2047 with wr_ptr wrap before the trigger: trigger accepted, post count 0, readout starts at trig_addr+1 mod 2048.
